// File: rtl/uart_rx_typed_dechunker.sv
// uart_rx_typed_dechunker
//
// Strips the escape framing from a UART RX byte stream and collects each
// chunk's type byte and payload. A complete chunk is copied into the output
// registers and announced with a one-cycle is_chunk_ready strobe.
//
// Wire framing: 00 00 = literal 0x00, 00 01 = end of chunk, 00 T (T>=2) =
// start of a chunk of type T, any other byte = literal payload byte.
//
// Optional feature macro: DECHUNKER_ERROR_EN
//   defined   : is_chunk_error port exists. An overflowed chunk raises an
//               error instead of being delivered, and an aborted (restarted)
//               chunk raises an error.
//   undefined : no error port. Overflowed chunks are delivered truncated to
//               capacity, and restarts are silent.
//
// Ports:
//   CLK               clock, rising edge
//   RST               synchronous active-high reset
//   is_rx_done        strobe: rx_data holds a new byte
//   rx_data           received byte
//   is_chunk_ready    one-cycle strobe: chunk outputs updated
//   chunk_byte_size   payload byte count of the delivered chunk
//   chunk_bytes       payload, byte i at [8i+7:8i], unused bytes zero
//   chunk_type        type byte of the delivered chunk
//   is_dechunker_idle 1 while no chunk is open
//   is_chunk_error    (DECHUNKER_ERROR_EN only) one-cycle error strobe
module uart_rx_typed_dechunker #(
    parameter int CONTENT_BUFFER_BYTE_SIZE = 3,
    parameter int BUFFER_INDEX_SIZE        = 32
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  is_rx_done,
    input  logic [7:0]                            rx_data,
    output logic                                  is_chunk_ready,
    output logic [BUFFER_INDEX_SIZE-1:0]          chunk_byte_size,
    output logic [CONTENT_BUFFER_BYTE_SIZE*8-1:0] chunk_bytes,
    output logic [7:0]                            chunk_type,
    output logic                                  is_dechunker_idle
`ifdef DECHUNKER_ERROR_EN
    ,
    output logic                                  is_chunk_error
`endif
);

    localparam int BUF_W = CONTENT_BUFFER_BYTE_SIZE * 8;
    localparam logic [BUFFER_INDEX_SIZE-1:0] CAP = BUFFER_INDEX_SIZE'(CONTENT_BUFFER_BYTE_SIZE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IDLE_ESC = 2'd1,
        BODY     = 2'd2,
        BODY_ESC = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [BUF_W-1:0]             buf_q, buf_d;
    logic [BUFFER_INDEX_SIZE-1:0] idx_q, idx_d;
    logic                         ovf_q, ovf_d;
    logic [7:0]                   type_q, type_d;
    logic [BUF_W-1:0]             out_bytes_d;
    logic [BUFFER_INDEX_SIZE-1:0] out_size_d;
    logic [7:0]                   out_type_d;
    logic                         ready_d;
    logic                         wr;
    logic                         eoc;
`ifdef DECHUNKER_ERROR_EN
    logic                         err_d;
`endif

    // Store one byte at the given index of the working buffer.
    function automatic logic [BUF_W-1:0] put_byte(input logic [BUF_W-1:0]             b,
                                                  input logic [BUFFER_INDEX_SIZE-1:0] idx,
                                                  input logic [7:0]                   d);
        logic [BUF_W-1:0] r;
        r = b;
        for (int i = 0; i < CONTENT_BUFFER_BYTE_SIZE; i++) begin
            if (idx == BUFFER_INDEX_SIZE'(i)) r[i*8 +: 8] = d;
        end
        return r;
    endfunction

    // The working buffer is never cleared between chunks, so stale bytes at
    // or beyond the write index must be zeroed on delivery.
    function automatic logic [BUF_W-1:0] mask_bytes(input logic [BUF_W-1:0]             b,
                                                    input logic [BUFFER_INDEX_SIZE-1:0] idx);
        logic [BUF_W-1:0] r;
        r = b;
        for (int i = 0; i < CONTENT_BUFFER_BYTE_SIZE; i++) begin
            if (BUFFER_INDEX_SIZE'(i) >= idx) r[i*8 +: 8] = 8'h00;
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q;
        type_d      = type_q;
        out_bytes_d = chunk_bytes;
        out_size_d  = chunk_byte_size;
        out_type_d  = chunk_type;
        ready_d     = 1'b0;
        wr          = 1'b0;
        eoc         = 1'b0;
`ifdef DECHUNKER_ERROR_EN
        err_d       = 1'b0;
`endif
        if (is_rx_done) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_data == 8'h00) state_d = IDLE_ESC;
                end
                IDLE_ESC: begin
                    if (rx_data >= 8'h02) begin
                        type_d  = rx_data;
                        idx_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = BODY;
                    end else begin
                        state_d = IDLE;
                    end
                end
                BODY: begin
                    if (rx_data == 8'h00) state_d = BODY_ESC;
                    else                  wr      = 1'b1;
                end
                BODY_ESC: begin
                    if (rx_data == 8'h00) begin
                        wr      = 1'b1;
                        state_d = BODY;
                    end else if (rx_data == 8'h01) begin
                        eoc     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Restart: the open chunk is abandoned.
                        type_d  = rx_data;
                        idx_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = BODY;
`ifdef DECHUNKER_ERROR_EN
                        err_d   = 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Index saturates at capacity; extra bytes only set the sticky flag.
        if (wr) begin
            if (idx_q < CAP) begin
                buf_d = put_byte(buf_q, idx_q, rx_data);
                idx_d = idx_q + BUFFER_INDEX_SIZE'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (eoc) begin
`ifdef DECHUNKER_ERROR_EN
            if (ovf_q) begin
                err_d = 1'b1;
            end else begin
                out_bytes_d = mask_bytes(buf_q, idx_q);
                out_size_d  = idx_q;
                out_type_d  = type_q;
                ready_d     = 1'b1;
            end
`else
            out_bytes_d = mask_bytes(buf_q, idx_q);
            out_size_d  = idx_q;
            out_type_d  = type_q;
            ready_d     = 1'b1;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= IDLE;
            buf_q           <= '0;
            idx_q           <= '0;
            ovf_q           <= 1'b0;
            type_q          <= '0;
            chunk_bytes     <= '0;
            chunk_byte_size <= '0;
            chunk_type      <= '0;
            is_chunk_ready  <= 1'b0;
`ifdef DECHUNKER_ERROR_EN
            is_chunk_error  <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            buf_q           <= buf_d;
            idx_q           <= idx_d;
            ovf_q           <= ovf_d;
            type_q          <= type_d;
            chunk_bytes     <= out_bytes_d;
            chunk_byte_size <= out_size_d;
            chunk_type      <= out_type_d;
            is_chunk_ready  <= ready_d;
`ifdef DECHUNKER_ERROR_EN
            is_chunk_error  <= err_d;
`endif
        end
    end

    // A lone 0x00 seen outside a chunk does not open one.
    assign is_dechunker_idle = (state_q == IDLE) || (state_q == IDLE_ESC);

endmodule

// File: tb/tb_uart_rx_typed_dechunker.sv
module tb_uart_rx_typed_dechunker;

    localparam int CAP = 3;
    localparam int NR  = 1500;
`ifdef DECHUNKER_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              is_rx_done = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              is_chunk_ready;
    logic [31:0]       chunk_byte_size;
    logic [CAP*8-1:0]  chunk_bytes;
    logic [7:0]        chunk_type;
    logic              is_dechunker_idle;
    logic              chunk_err;

    uart_rx_typed_dechunker #(
        .CONTENT_BUFFER_BYTE_SIZE(CAP),
        .BUFFER_INDEX_SIZE(32)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .is_rx_done(is_rx_done),
        .rx_data(rx_data),
        .is_chunk_ready(is_chunk_ready),
        .chunk_byte_size(chunk_byte_size),
        .chunk_bytes(chunk_bytes),
        .chunk_type(chunk_type),
        .is_dechunker_idle(is_dechunker_idle)
`ifdef DECHUNKER_ERROR_EN
        ,
        .is_chunk_error(chunk_err)
`endif
    );

`ifndef DECHUNKER_ERROR_EN
    assign chunk_err = 1'b0;
`endif

    always #5 CLK = ~CLK;

    int pass_cnt = 0;
    int total_cnt = 0;
    int rdy_cnt;
    int err_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    // Drive one strobe; outputs are sampled 1ns after the capturing edge.
    task automatic send(input logic [7:0] b);
        rx_data    = b;
        is_rx_done = 1'b1;
        @(posedge CLK);
        #1;
        is_rx_done = 1'b0;
        rdy_cnt += int'(is_chunk_ready);
        err_cnt += int'(chunk_err);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  s[8];
        int          n;
        int          rdy;
        int          err;
        logic [7:0]  ty;
        logic [31:0] sz;
        logic [23:0] by;
    } vec_t;

    vec_t tv[5];

    // Reference model data: a whole random stream, decoded in one pass.
    logic [7:0]       rs[NR];
    int               ev[NR];       // 0 none, 1 ready, 2 error
    logic [7:0]       ev_type[NR];
    logic [31:0]      ev_size[NR];
    logic [CAP*8-1:0] ev_bytes[NR];

    task automatic model_run();
        logic [7:0] pl[$];
        bit         open;
        logic [7:0] ty;
        logic [7:0] t;
        int         i;
        int         k;
        int         n;
        logic [CAP*8-1:0] b;
        open = 1'b0;
        ty   = 8'h00;
        i    = 0;
        for (int j = 0; j < NR; j++) ev[j] = 0;
        while (i < NR) begin
            if (rs[i] != 8'h00) begin
                if (open) pl.push_back(rs[i]);
                i++;
            end else begin
                if (i + 1 >= NR) break;
                t = rs[i+1];
                k = i + 1;
                i += 2;
                if (!open) begin
                    if (t >= 8'h02) begin
                        open = 1'b1;
                        ty   = t;
                        pl.delete();
                    end
                end else if (t == 8'h00) begin
                    pl.push_back(8'h00);
                end else if (t == 8'h01) begin
                    open = 1'b0;
                    if (ERR_EN && pl.size() > CAP) begin
                        ev[k] = 2;
                    end else begin
                        n = (pl.size() > CAP) ? CAP : pl.size();
                        b = '0;
                        for (int j = 0; j < n; j++) b[8*j +: 8] = pl[j];
                        ev[k]       = 1;
                        ev_type[k]  = ty;
                        ev_size[k]  = n;
                        ev_bytes[k] = b;
                    end
                end else begin
                    ty = t;
                    pl.delete();
                    if (ERR_EN) ev[k] = 2;
                end
            end
        end
    endtask

    initial begin
        logic [7:0]       e_ty;
        logic [31:0]      e_sz;
        logic [CAP*8-1:0] e_by;
        int               r;

        tv[0].s = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h00, 8'h01, 8'h00};
        tv[0].n = 7; tv[0].rdy = 1; tv[0].err = 0;
        tv[0].ty = 8'h02; tv[0].sz = 3; tv[0].by = 24'h030201;

        tv[1].s = '{8'h00, 8'h05, 8'h00, 8'h00, 8'h07, 8'h00, 8'h01, 8'h00};
        tv[1].n = 7; tv[1].rdy = 1; tv[1].err = 0;
        tv[1].ty = 8'h05; tv[1].sz = 2; tv[1].by = 24'h000700;

        tv[2].s = '{8'h00, 8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        tv[2].n = 4; tv[2].rdy = 1; tv[2].err = 0;
        tv[2].ty = 8'h03; tv[2].sz = 0; tv[2].by = 24'h000000;

        tv[3].s = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h01};
        tv[3].n = 8;
        if (ERR_EN) begin
            tv[3].rdy = 0; tv[3].err = 1;
            tv[3].ty = 8'h00; tv[3].sz = 0; tv[3].by = 24'h000000;
        end else begin
            tv[3].rdy = 1; tv[3].err = 0;
            tv[3].ty = 8'h02; tv[3].sz = 3; tv[3].by = 24'hCCBBAA;
        end

        tv[4].s = '{8'h00, 8'h02, 8'hAA, 8'h00, 8'h04, 8'hBB, 8'h00, 8'h01};
        tv[4].n = 8; tv[4].rdy = 1; tv[4].err = ERR_EN ? 1 : 0;
        tv[4].ty = 8'h04; tv[4].sz = 1; tv[4].by = 24'h0000BB;

        // Reset state
        do_reset();
        chk("rst_ready", 64'(is_chunk_ready), 64'd0);
        chk("rst_size", 64'(chunk_byte_size), 64'd0);
        chk("rst_bytes", 64'(chunk_bytes), 64'd0);
        chk("rst_type", 64'(chunk_type), 64'd0);
        chk("rst_idle", 64'(is_dechunker_idle), 64'd1);

        // Directed table
        for (int v = 0; v < 5; v++) begin
            do_reset();
            rdy_cnt = 0;
            err_cnt = 0;
            for (int j = 0; j < tv[v].n; j++) begin
                send(tv[v].s[j]);
                if (j == 1) chk($sformatf("v%0d_busy", v), 64'(is_dechunker_idle), 64'd0);
            end
            @(posedge CLK);
            #1;
            rdy_cnt += int'(is_chunk_ready);
            err_cnt += int'(chunk_err);
            chk($sformatf("v%0d_rdy_pulses", v), 64'(rdy_cnt), 64'(tv[v].rdy));
`ifdef DECHUNKER_ERROR_EN
            chk($sformatf("v%0d_err_pulses", v), 64'(err_cnt), 64'(tv[v].err));
`endif
            chk($sformatf("v%0d_type", v), 64'(chunk_type), 64'(tv[v].ty));
            chk($sformatf("v%0d_size", v), 64'(chunk_byte_size), 64'(tv[v].sz));
            chk($sformatf("v%0d_bytes", v), 64'(chunk_bytes), 64'(tv[v].by));
            chk($sformatf("v%0d_idle", v), 64'(is_dechunker_idle), 64'd1);

            // After the empty chunk: stray bytes with no chunk open.
            if (v == 2) begin
                rdy_cnt = 0;
                send(8'h11);
                chk("stray_idle0", 64'(is_dechunker_idle), 64'd1);
                send(8'h22);
                chk("stray_idle1", 64'(is_dechunker_idle), 64'd1);
                send(8'h00);
                chk("stray_idle2", 64'(is_dechunker_idle), 64'd1);
                send(8'h00);
                chk("stray_idle3", 64'(is_dechunker_idle), 64'd1);
                chk("stray_no_rdy", 64'(rdy_cnt), 64'd0);
                chk("stray_hold_type", 64'(chunk_type), 64'h03);
            end
        end

        // Ready strobe exactly one cycle, then outputs hold
        do_reset();
        send(8'h00); send(8'h06); send(8'h42); send(8'h00); send(8'h01);
        chk("pulse_hi", 64'(is_chunk_ready), 64'd1);
        @(posedge CLK); #1;
        chk("pulse_lo", 64'(is_chunk_ready), 64'd0);
        chk("hold_bytes", 64'(chunk_bytes), 64'h000042);

        // Mid-chunk reset, with a strobe in the reset cycle
        send(8'h00); send(8'h02); send(8'hAA);
        chk("mid_busy", 64'(is_dechunker_idle), 64'd0);
        RST = 1'b1; rx_data = 8'h00; is_rx_done = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; is_rx_done = 1'b0;
        chk("mr_bytes", 64'(chunk_bytes), 64'd0);
        chk("mr_type", 64'(chunk_type), 64'd0);
        chk("mr_size", 64'(chunk_byte_size), 64'd0);
        chk("mr_idle", 64'(is_dechunker_idle), 64'd1);
        rdy_cnt = 0;
        send(8'h02); send(8'hAA); send(8'h00); send(8'h01);
        send(8'h00); send(8'h01);
        @(posedge CLK); #1;
        rdy_cnt += int'(is_chunk_ready);
        chk("mr_no_rdy", 64'(rdy_cnt), 64'd0);
        chk("mr_idle_end", 64'(is_dechunker_idle), 64'd1);

        // Randomized stream against the reference model
        do_reset();
        for (int j = 0; j < NR; j++) begin
            r = $urandom_range(0, 9);
            if (r <= 2)      rs[j] = 8'h00;
            else if (r == 3) rs[j] = 8'h01;
            else if (r == 4) rs[j] = 8'($urandom_range(2, 5));
            else             rs[j] = 8'($urandom_range(0, 255));
        end
        model_run();
        e_ty = 8'h00;
        e_sz = 32'd0;
        e_by = '0;
        for (int j = 0; j < NR; j++) begin
            send(rs[j]);
            if (ev[j] == 1) begin
                e_ty = ev_type[j];
                e_sz = ev_size[j];
                e_by = ev_bytes[j];
            end
            chk($sformatf("rnd%0d_rdy", j), 64'(is_chunk_ready), 64'(ev[j] == 1));
`ifdef DECHUNKER_ERROR_EN
            chk($sformatf("rnd%0d_err", j), 64'(chunk_err), 64'(ev[j] == 2));
`endif
            chk($sformatf("rnd%0d_type", j), 64'(chunk_type), 64'(e_ty));
            chk($sformatf("rnd%0d_size", j), 64'(chunk_byte_size), 64'(e_sz));
            chk($sformatf("rnd%0d_bytes", j), 64'(chunk_bytes), 64'(e_by));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK); #1;
                chk($sformatf("rnd%0d_gap_rdy", j), 64'(is_chunk_ready), 64'd0);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
